uart_rx_core: RTL

//   16x-oversampling UART receiver. It sits directly upstream of the peripheral block's RX_buffer.
//   It synchronises the RX pin, detects and validates start bits, and samples 8N1 frames (LSB first)

---
 rtl/uart_rx_core.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampling UART receiver with a 3-sample majority vote and an 8N1 frame.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
    parameter int unsigned BAUD_DIV    = 651,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [15:0] DivLast = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    // Synchroniser presets to idle-high so releasing reset cannot look like a start bit.
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], RX};
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];

    logic [15:0] div;
    logic        tick;

    assign tick = (div == DivLast);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 16'd1;
        end
    end

    state_e     state;
    logic [3:0] os;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       s7;
    logic       s8;
    logic       maj;
    logic       par_bad;

    // rx_s is the third sample when this is evaluated at os==9.
    assign maj = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = ^{shreg, par_bit};
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            os         <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (tick) begin
                if (state != StIdle) begin
                    os <= os + 4'd1;
                    if (os == 4'd7) s7 <= rx_s;
                    if (os == 4'd8) s8 <= rx_s;
                end
                unique case (state)
                    StIdle: begin
                        if (!rx_s) begin
                            state <= StStart;
                            os    <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (os == 4'd9 && maj) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else if (os == 4'd15) begin
                            state   <= StData;
                            os      <= '0;
                            bit_idx <= '0;
                        end
                    end
                    StData: begin
                        if (os == 4'd9) shreg <= {maj, shreg[7:1]};
                        if (os == 4'd15) begin
                            os      <= '0;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= StParity;
`else
                                state <= StStop;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (os == 4'd9) par_bit <= maj;
                        if (os == 4'd15) begin
                            os    <= '0;
                            state <= StStop;
                        end
                    end
`endif
                    // Deciding at mid-stop-bit leaves half a bit to catch a back-to-back start.
                    StStop: begin
                        if (os == 4'd9) begin
                            parity_err <= par_bad;
                            if (maj) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                                if (!par_bad) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end
                            end else begin
                                state     <= StBreak;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    StBreak: begin
                        if (rx_s) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
